// File: rtl/lsu_data_memory.sv
// Word-organised data memory behind a load/store request port: clears itself after
// reset, then serves byte/half/word loads and stores with a single-cycle registered response.
module lsu_data_memory #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  // state | meaning
  // INIT  | clearing one word per cycle at clr_cnt, requests refused
  // READY | accepting one request per cycle until reset
  typedef enum logic {INIT, READY} state_t;

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  logic [MEM_AW-1:0] clr_cnt;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic [1:0]        lane;
  logic              is_b, is_h, is_w, is_bu, is_hu;
  logic              fault;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;

  assign accept   = req_valid & req_ready;
  assign word_idx = {2'b00, req_addr[ADDR_W-1:2]};
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign lane     = req_addr[1:0];

  assign is_b  = (req_size == 3'b000);
  assign is_h  = (req_size == 3'b001);
  assign is_w  = (req_size == 3'b010);
  assign is_bu = (req_size == 3'b100);
  assign is_hu = (req_size == 3'b101);

  always_comb begin
    fault = 1'b0;
    if (word_idx >= ADDR_W'(DEPTH))                fault = 1'b1;
    if (!(is_b | is_h | is_w | is_bu | is_hu))     fault = 1'b1;
    if ((is_h | is_hu) && lane[0])                 fault = 1'b1;
    if (is_w && (lane != 2'b00))                   fault = 1'b1;
    if (req_write && (is_bu | is_hu))              fault = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes
  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = req_wdata;
    if (is_b | is_bu) begin
      byte_en   = 4'b0001 << lane;
      wdata_rep = {4{req_wdata[7:0]}};
    end else if (is_h | is_hu) begin
      byte_en   = lane[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{req_wdata[15:0]}};
    end else if (is_w) begin
      byte_en   = 4'b1111;
    end
  end

  assign rd_word = mem[mem_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'h0;
    case (req_size)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_cnt] <= 32'h0;
    end else if (accept && req_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & fault;
      rsp_data  <= (accept && !req_write && !fault) ? load_data : 32'h0;
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == MEM_AW'(DEPTH - 1)) begin
            state     <= READY;
            req_ready <= 1'b1;
            clr_cnt   <= '0;
          end
        end
        READY: begin
          req_ready <= 1'b1;
        end
        default: begin
          state     <= INIT;
          req_ready <= 1'b0;
          clr_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data_memory.sv
// Scoreboard bench for lsu_data_memory: a byte-array reference model predicts each
// response at issue time; a negedge monitor pops and compares whatever the DUT returns.
module tb_lsu_data_memory;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  lsu_data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mdl [DEPTH*4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h00;
  endtask

  // Reference behaviour: memory as a flat little-endian byte array
  task automatic model(input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] d, output logic e);
    int          nb;
    logic        sgn;
    logic [31:0] v;
    nb  = 0;
    sgn = 1'b0;
    e   = 1'b0;
    d   = 32'h0;
    case (sz)
      3'd0: begin nb = 1; sgn = 1'b1; end
      3'd1: begin nb = 2; sgn = 1'b1; end
      3'd2: begin nb = 4; sgn = 1'b0; end
      3'd4: begin nb = 1; sgn = 1'b0; end
      3'd5: begin nb = 2; sgn = 1'b0; end
      default: e = 1'b1;
    endcase
    if ((a >> 2) >= DEPTH) e = 1'b1;
    if (nb > 0 && (a % nb) != 0) e = 1'b1;
    if (w && (sz == 3'd4 || sz == 3'd5)) e = 1'b1;
    if (e) return;
    if (w) begin
      for (int k = 0; k < nb; k++) mdl[a + k] = 8'(wd >> (8*k));
    end else begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v = v | (32'(mdl[a + k]) << (8*k));
      if (sgn && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      d = v;
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
  endtask

  task automatic issue(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    model(w, sz, a, wd, e.data, e.err);
    e.acc = cyc + 1;
    sb.push_back(e);
    drive(w, sz, a, wd);
    @(negedge clk);
  endtask

  // Directed requests carry hand-derived expectations; the model still tracks the stores
  task automatic issue_exp(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] xd, input logic xe);
    exp_t        e;
    logic [31:0] md;
    logic        me;
    model(w, sz, a, wd, md, me);
    e.data = xd;
    e.err  = xe;
    e.acc  = cyc + 1;
    sb.push_back(e);
    drive(w, sz, a, wd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (n < 4*DEPTH) begin
      @(posedge clk);
      #1;
      n++;
      if (req_ready) break;
    end
    chk("init_cycles", n, DEPTH);
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: req_ready=0 after %0d cycles, expected 1", n);
      finish_run();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 data=%h err=%b, expected no response", rsp_data, rsp_err);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", cyc, e.acc);
      end
    end else if (sb.size() > 0 && sb[0].acc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_rsp: rsp_valid=0 at cycle %0d, expected response %h", cyc, e.data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  logic [2:0]  legal [5];
  logic [2:0]  sz;
  logic [31:0] a;

  initial begin
    legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 3'd0;
    req_addr  = '0;
    req_wdata = '0;

    #2 reset = 1'b1;
    #1;
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_err", 32'(rsp_err), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    wait_ready();

    issue_exp(1'b0, 3'd2, 32'h0, 32'h0, 32'h0000_0000, 1'b0);

    issue_exp(1'b1, 3'd2, 32'h10, 32'h80FF7F01, 32'h0, 1'b0);
    issue_exp(1'b0, 3'd0, 32'h10, 32'h0, 32'h0000_0001, 1'b0);
    issue_exp(1'b0, 3'd0, 32'h11, 32'h0, 32'h0000_007F, 1'b0);
    issue_exp(1'b0, 3'd0, 32'h12, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue_exp(1'b0, 3'd4, 32'h12, 32'h0, 32'h0000_00FF, 1'b0);
    issue_exp(1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF_80FF, 1'b0);
    issue_exp(1'b0, 3'd5, 32'h12, 32'h0, 32'h0000_80FF, 1'b0);

    issue_exp(1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0, 1'b0);
    issue_exp(1'b1, 3'd0, 32'h21, 32'hFFFF_FFAB, 32'h0, 1'b0);
    issue_exp(1'b0, 3'd2, 32'h20, 32'h0, 32'h1122_AB44, 1'b0);

    issue_exp(1'b0, 3'd2, 32'h22, 32'h0, 32'h0, 1'b1);
    issue_exp(1'b1, 3'd1, 32'h23, 32'h5555_5555, 32'h0, 1'b1);
    issue_exp(1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1);
    issue_exp(1'b0, 3'd3, 32'h20, 32'h0, 32'h0, 1'b1);
    issue_exp(1'b1, 3'd3, 32'h20, 32'hAAAA_AAAA, 32'h0, 1'b1);
    issue_exp(1'b1, 3'd4, 32'h20, 32'hAAAA_AAAA, 32'h0, 1'b1);
    issue_exp(1'b1, 3'd2, 32'h100, 32'hAAAA_AAAA, 32'h0, 1'b1);
    issue_exp(1'b0, 3'd2, 32'h20, 32'h0, 32'h1122_AB44, 1'b0);
    issue_exp(1'b0, 3'd2, 32'h10, 32'h0, 32'h80FF_7F01, 1'b0);
    idle(2);

    for (int i = 0; i < 8; i++) issue(1'b1, 3'd2, 32'h40 + 32'(4*i), $urandom);
    for (int i = 0; i < 8; i++) issue(1'b0, 3'd2, 32'h40 + 32'(4*i), 32'h0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      if ($urandom_range(0, 9) == 0) sz = 3'($urandom_range(0, 7));
      else                           sz = legal[$urandom_range(0, 4)];
      case ($urandom_range(0, 19))
        0:       a = $urandom;
        1, 2:    a = 32'($urandom_range(0, 1023));
        default: a = 32'($urandom_range(0, DEPTH*4 - 1));
      endcase
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), sz, a, $urandom);
    end
    idle(3);

    issue(1'b1, 3'd2, 32'h30, 32'hDEAD_BEEF);
    issue(1'b0, 3'd2, 32'h30, 32'h0);
    idle(3);
    drive(1'b0, 3'd2, 32'h30, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("midreset_req_ready", 32'(req_ready), 0);
    chk("midreset_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk);
    #1;
    chk("midreset_no_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    clear_model();
    wait_ready();
    issue_exp(1'b0, 3'd2, 32'h30, 32'h0, 32'h0, 1'b0);
    issue_exp(1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 1'b0);
    issue_exp(1'b0, 3'd2, 32'h44, 32'h0, 32'h0, 1'b0);
    idle(1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    finish_run();
  end

endmodule
